// File: rtl/pipe_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pipe_pkg : shared types and encodings for the pipeline hazard unit |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_ME = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;

  // A writer only matters if it targets a real register (r0 is hardwired zero).
  function automatic logic reg_hit(input logic wr, input logic [REG_W-1:0] td,
                                   input logic [REG_W-1:0] src);
    return wr && (td != '0) && (td == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fwd_unit : EX-operand bypass select for one source register        |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] me_td,
  input  logic             me_WREG,
  input  logic             me_LW,
  input  logic [REG_W-1:0] wb_td,
  input  logic             wb_WREG,
  output logic [1:0]       sel
);

  // A load in ME has no data yet, so it cannot feed the bypass.
  always_comb begin
    sel = FWD_RF;
    if (reg_hit(me_WREG && !me_LW, me_td, src)) begin
      sel = FWD_ME;
    end else if (reg_hit(wb_WREG, wb_td, src)) begin
      sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/flush/freeze sequencing and forwarding    |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch_taken,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_td,
  input  logic             ex_WREG,
  input  logic             ex_LW,
  input  logic [REG_W-1:0] me_td,
  input  logic             me_WREG,
  input  logic             me_LW,
  input  logic             me_WMEM,
  input  logic             mem_ready,
  input  logic [REG_W-1:0] wb_td,
  input  logic             wb_WREG,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_me_en,
  output logic             me_wb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       frozen;
  logic       mem_busy;
  logic       load_use;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign mem_busy = me_LW || me_WMEM;
  assign load_use = ex_LW && (reg_hit(ex_WREG && id_use_rs, ex_td, id_rs) ||
                              reg_hit(ex_WREG && id_use_rt, ex_td, id_rt));

  fwd_unit u_fwd_a (
    .src     (ex_rs),
    .me_td   (me_td),
    .me_WREG (me_WREG),
    .me_LW   (me_LW),
    .wb_td   (wb_td),
    .wb_WREG (wb_WREG),
    .sel     (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .src     (ex_rt),
    .me_td   (me_td),
    .me_WREG (me_WREG),
    .me_LW   (me_LW),
    .wb_td   (wb_td),
    .wb_WREG (wb_WREG),
    .sel     (fwd_b_raw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ST_ERROR) begin
        mem_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    frozen       = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_bubble = 1'b0;
    ex_me_en     = 1'b1;
    me_wb_bubble = 1'b0;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;

    case (state)
      ST_RUN: begin
        if (mem_busy && !mem_ready) begin
          frozen       = 1'b1;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          frozen = 1'b1;
          if (wait_cnt == TIMEOUT_C) begin
            state_nxt = ST_ERROR;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end else begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end
      end
      ST_ERROR: begin
        frozen = 1'b1;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    // A branch seen during a load-use stall is re-evaluated once IF/ID releases.
    if (frozen) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_me_en     = 1'b0;
      me_wb_bubble = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (id_branch_taken) begin
      if_id_flush  = 1'b1;
    end

    if (!rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_bubble = 1'b0;
      ex_me_en     = 1'b0;
      me_wb_bubble = 1'b0;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (if_id_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed self-checking bench                 |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_td, me_td, wb_td;
  logic       id_use_rs, id_use_rt, id_branch_taken;
  logic       ex_WREG, ex_LW, me_WREG, me_LW, me_WMEM, mem_ready, wb_WREG;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
  logic       ex_me_en, me_wb_bubble, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch_taken(id_branch_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_td(ex_td), .ex_WREG(ex_WREG), .ex_LW(ex_LW),
    .me_td(me_td), .me_WREG(me_WREG), .me_LW(me_LW), .me_WMEM(me_WMEM),
    .mem_ready(mem_ready), .wb_td(wb_td), .wb_WREG(wb_WREG),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .ex_me_en(ex_me_en),
    .me_wb_bubble(me_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_branch_taken = 0;
    ex_rs = 0; ex_rt = 0; ex_td = 0; ex_WREG = 0; ex_LW = 0;
    me_td = 0; me_WREG = 0; me_LW = 0; me_WMEM = 0; mem_ready = 0;
    wb_td = 0; wb_WREG = 0;
  endtask

  task automatic set_load_use();
    ex_LW = 1; ex_WREG = 1; ex_td = 5; id_rs = 5; id_use_rs = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with hazard-provoking inputs applied: outputs must stay quiet.
    clr();
    rst = 0;
    me_WREG = 1; me_td = 7; ex_rs = 7; me_LW = 1; mem_ready = 0;
    #2;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_if_id_en", if_id_en, 0);
    chk("rst_id_ex_en", id_ex_en, 0);
    chk("rst_ex_me_en", ex_me_en, 0);
    chk("rst_bubble", me_wb_bubble, 0);
    chk("rst_fwd_a", fwd_a, 0);
    tick(); tick();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_mem_err", mem_err, 0);
    clr();
    rst = 1;
    #1;
    chk("run_pc_en", pc_en, 1);
    chk("run_ex_me_en", ex_me_en, 1);

    // Load-use stall
    set_load_use();
    #1;
    chk("lu_pc_en", pc_en, 0);
    chk("lu_if_id_en", if_id_en, 0);
    chk("lu_bubble", id_ex_bubble, 1);
    chk("lu_ex_me_en", ex_me_en, 1);
    id_use_rs = 0;
    #1;
    chk("lu_unused_rs", pc_en, 1);
    id_use_rs = 1;
    tick();
    clr();
    #1;
    chk("lu_after_pc_en", pc_en, 1);
    chk("lu_after_bubble", id_ex_bubble, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    ex_LW = 1; ex_WREG = 1; ex_td = 0; id_rs = 0; id_use_rs = 1;
    #1;
    chk("lu_r0", pc_en, 1);
    clr();
    ex_LW = 1; ex_WREG = 1; ex_td = 9; id_rt = 9; id_use_rt = 1;
    #1;
    chk("lu_rt", pc_en, 0);
    clr();
    #1;

    // Branch flush, then branch coinciding with a load-use stall
    id_branch_taken = 1;
    #1;
    chk("br_flush", if_id_flush, 1);
    chk("br_pc_en", pc_en, 1);
    chk("br_id_ex_en", id_ex_en, 1);
    tick();
    clr();
    #1;
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_flush_off", if_id_flush, 0);
    id_branch_taken = 1;
    set_load_use();
    #1;
    chk("brlu_flush", if_id_flush, 0);
    chk("brlu_pc_en", pc_en, 0);
    tick();
    ex_LW = 0; ex_WREG = 0; ex_td = 0; id_rs = 0; id_use_rs = 0;
    #1;
    chk("brlu_flush_next", if_id_flush, 1);
    chk("brlu_flush_cnt_mid", flush_cnt, 1);
    tick();
    clr();
    #1;
    chk("brlu_flush_cnt", flush_cnt, 2);
    chk("brlu_stall_cnt", stall_cnt, 2);

    // Memory wait: three frozen cycles then release
    me_LW = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_pc_en", pc_en, 0);
      chk("mw_ex_me_en", ex_me_en, 0);
      chk("mw_bubble", me_wb_bubble, 1);
      tick();
    end
    mem_ready = 1;
    #1;
    chk("mw_rel_pc_en", pc_en, 1);
    chk("mw_rel_id_ex_en", id_ex_en, 1);
    chk("mw_rel_ex_me_en", ex_me_en, 1);
    chk("mw_rel_bubble", me_wb_bubble, 0);
    tick();
    clr();
    #1;
    chk("mw_back_run", pc_en, 1);
    chk("mw_stall_cnt", stall_cnt, 5);
    me_WMEM = 1; mem_ready = 1;
    #1;
    chk("single_pc_en", pc_en, 1);
    chk("single_bubble", me_wb_bubble, 0);
    tick();
    clr();
    #1;

    // Timeout to ERROR (MEM_TIMEOUT=4)
    me_LW = 1; mem_ready = 0;
    repeat (4) tick();
    chk("to_no_err_yet", mem_err, 0);
    tick();
    chk("to_mem_err", mem_err, 1);
    chk("to_pc_en", pc_en, 0);
    mem_ready = 1;
    #1;
    chk("err_pc_en", pc_en, 0);
    chk("err_if_id_en", if_id_en, 0);
    chk("err_bubble", me_wb_bubble, 1);
    tick();
    chk("err_sticky", mem_err, 1);
    chk("err_stall_cnt", stall_cnt, 11);
    rst = 0;
    #1;
    chk("err_rst_mem_err", mem_err, 0);
    chk("err_rst_stall", stall_cnt, 0);
    chk("err_rst_pc_en", pc_en, 0);
    tick();
    clr();
    rst = 1;
    #1;
    chk("err_cleared_pc_en", pc_en, 1);

    // Asynchronous reset inside MEM_WAIT, no clock edge while low
    me_LW = 1; mem_ready = 0;
    tick(); tick();
    #2;
    rst = 0;
    #2;
    chk("async_stall", stall_cnt, 0);
    clr();
    rst = 1;
    #1;
    chk("async_run_pc_en", pc_en, 1);
    chk("async_run_bubble", me_wb_bubble, 0);

    // Forwarding
    mem_ready = 1;
    me_td = 7; wb_td = 7; ex_rs = 7; ex_rt = 7; me_WREG = 1; wb_WREG = 1;
    #1;
    chk("fwd_a_me", fwd_a, 2'b10);
    chk("fwd_b_me", fwd_b, 2'b10);
    me_LW = 1;
    #1;
    chk("fwd_a_wb", fwd_a, 2'b01);
    chk("fwd_b_wb", fwd_b, 2'b01);
    ex_rs = 0;
    #1;
    chk("fwd_a_r0", fwd_a, 2'b00);
    wb_WREG = 0;
    #1;
    chk("fwd_b_none", fwd_b, 2'b00);
    me_LW = 0; wb_WREG = 1; wb_td = 3; ex_rt = 3;
    #1;
    chk("fwd_b_wb_only", fwd_b, 2'b01);
    clr();
    #1;

    // Saturation (CNT_W=4)
    set_load_use();
    repeat (10) tick();
    chk("sat_stall_10", stall_cnt, 10);
    repeat (10) tick();
    chk("sat_stall_20", stall_cnt, 15);
    repeat (2) tick();
    chk("sat_stall_hold", stall_cnt, 15);
    clr();
    id_branch_taken = 1;
    repeat (20) tick();
    chk("sat_flush", flush_cnt, 15);
    clr();
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
